// File: rtl/blind_pixel_table_ctrl.sv
// Double-buffered blind-pixel table controller: arbitrates host/calibration
// access to the shadow bank, swaps banks on a video SOP and copies active to shadow.
module blind_pixel_table_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] h_address,
    input  logic                  h_read,
    input  logic                  h_write,
    input  logic [31:0]           h_writedata,
    input  logic [3:0]            h_byteenable,
    output logic                  h_waitrequest,
    output logic [31:0]           h_readdata,
    output logic                  h_readdatavalid,
    input  logic [ADDR_WIDTH-1:0] c_address,
    input  logic                  c_write,
    input  logic [31:0]           c_writedata,
    output logic                  c_waitrequest,
    input  logic                  commit,
    output logic                  commit_pending,
    output logic                  copy_busy,
    output logic                  swap_done,
    output logic                  active_bank,
    input  logic [DATA_WIDTH-1:0] vid_data,
    input  logic                  vid_valid,
    input  logic                  vid_ready,
    input  logic                  vid_sop,
    output logic [ADDR_WIDTH:0]   ram_address,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [31:0]           ram_writedata,
    output logic [3:0]            ram_byteenable,
    input  logic [31:0]           ram_readdata
);

    typedef enum logic [1:0] {IDLE, PENDING, COPY_RD, COPY_WR} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  commit_req;
    logic                  last_host;
    logic                  rd_valid;
    logic                  active_q;
    logic                  swap_q;
    logic                  frame_sop;
    logic                  copy_active;
    logic                  idx_last;
    logic                  h_req;
    logic                  c_req;
    logic                  grant_h;
    logic                  grant_c;
    logic                  vid_unused;

    // Control packets carry a non-zero type nibble and must not trigger a swap.
    assign frame_sop   = vid_valid & vid_ready & vid_sop & (vid_data[3:0] == 4'h0);
    assign vid_unused  = ^vid_data;
    assign copy_active = (state == COPY_RD) || (state == COPY_WR);
    assign idx_last    = (idx == '1);

    assign h_req   = h_read | h_write;
    assign c_req   = c_write;
    assign grant_h = ~copy_active & h_req & (~c_req | ~last_host);
    assign grant_c = ~copy_active & c_req & (~h_req | last_host);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit) state_nxt = PENDING;
            PENDING: if (frame_sop) state_nxt = COPY_RD;
            COPY_RD: state_nxt = COPY_WR;
            COPY_WR: begin
                if (idx_last) state_nxt = (commit_req || commit) ? PENDING : IDLE;
                else          state_nxt = COPY_RD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            commit_req <= 1'b0;
            last_host  <= 1'b0;
            rd_valid   <= 1'b0;
            active_q   <= 1'b0;
            swap_q     <= 1'b0;
        end else begin
            swap_q   <= 1'b0;
            rd_valid <= grant_h & h_read;
            if (grant_h)      last_host <= 1'b1;
            else if (grant_c) last_host <= 1'b0;
            if (state == PENDING && frame_sop) begin
                active_q <= ~active_q;
                swap_q   <= 1'b1;
                idx      <= '0;
            end else if (state == COPY_WR) begin
                idx <= idx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
            // A commit landing in the final copy beat is consumed by the PENDING transition.
            if (state == COPY_WR && idx_last) commit_req <= 1'b0;
            else if (copy_active && commit)   commit_req <= 1'b1;
        end
    end

    always_comb begin
        ram_address    = '0;
        ram_read       = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = '0;
        ram_byteenable = 4'hF;
        h_waitrequest  = 1'b0;
        c_waitrequest  = 1'b0;
        case (state)
            COPY_RD: begin
                ram_read      = 1'b1;
                ram_address   = {active_q, idx};
                h_waitrequest = 1'b1;
                c_waitrequest = 1'b1;
            end
            COPY_WR: begin
                ram_write     = 1'b1;
                ram_address   = {~active_q, idx};
                ram_writedata = ram_readdata;
                h_waitrequest = 1'b1;
                c_waitrequest = 1'b1;
            end
            default: begin
                h_waitrequest = h_req & ~grant_h;
                c_waitrequest = c_req & ~grant_c;
                if (grant_h) begin
                    ram_address    = {~active_q, h_address};
                    ram_read       = h_read;
                    ram_write      = h_write & ~h_read;
                    ram_writedata  = h_writedata;
                    ram_byteenable = h_byteenable;
                end else if (grant_c) begin
                    ram_address   = {~active_q, c_address};
                    ram_write     = 1'b1;
                    ram_writedata = c_writedata;
                end
            end
        endcase
    end

    assign copy_busy       = copy_active;
    assign commit_pending  = (state == PENDING) || commit_req;
    assign swap_done       = swap_q;
    assign active_bank     = active_q;
    assign h_readdatavalid = rd_valid;
    assign h_readdata      = rd_valid ? ram_readdata : '0;

endmodule

// File: tb/tb_blind_pixel_table_ctrl.sv
// Bench for blind_pixel_table_ctrl: RAM model, directed vector table, random
// arbitration traffic against a reference model, and commit/copy/reset sequences.
module tb_blind_pixel_table_ctrl;

    logic        clk, rst_n;
    logic [6:0]  h_address, c_address;
    logic        h_read, h_write, c_write, commit;
    logic [31:0] h_writedata, c_writedata, h_readdata, ram_writedata, ram_readdata;
    logic [3:0]  h_byteenable, ram_byteenable;
    logic        h_waitrequest, h_readdatavalid, c_waitrequest;
    logic        commit_pending, copy_busy, swap_done, active_bank;
    logic [9:0]  vid_data;
    logic        vid_valid, vid_ready, vid_sop;
    logic [7:0]  ram_address;
    logic        ram_read, ram_write;

    blind_pixel_table_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .h_address(h_address), .h_read(h_read), .h_write(h_write),
        .h_writedata(h_writedata), .h_byteenable(h_byteenable),
        .h_waitrequest(h_waitrequest), .h_readdata(h_readdata),
        .h_readdatavalid(h_readdatavalid),
        .c_address(c_address), .c_write(c_write), .c_writedata(c_writedata),
        .c_waitrequest(c_waitrequest),
        .commit(commit), .commit_pending(commit_pending), .copy_busy(copy_busy),
        .swap_done(swap_done), .active_bank(active_bank),
        .vid_data(vid_data), .vid_valid(vid_valid), .vid_ready(vid_ready), .vid_sop(vid_sop),
        .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable),
        .ram_readdata(ram_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External RAM: 2 banks x 128 words, byte-enabled writes, 1-cycle read latency.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_write) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
        end
        if (ram_read) ram_readdata <= mem[ram_address];
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [256];
    logic        exp_active = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        h_read = 0; h_write = 0; c_write = 0; commit = 0;
        vid_valid = 0; vid_ready = 0; vid_sop = 0; vid_data = '0;
        h_address = '0; c_address = '0; h_writedata = '0; c_writedata = '0; h_byteenable = 4'hF;
    endtask

    task automatic drive_vid(input logic [9:0] d);
        vid_valid = 1; vid_ready = 1; vid_sop = 1; vid_data = d;
    endtask

    task automatic vid_off();
        vid_valid = 0; vid_ready = 0; vid_sop = 0; vid_data = '0;
    endtask

    task automatic check_banks(input string name);
        int bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
        chk(name, bad, 0);
    endtask

    // Copy in the direction implied by the new active bank.
    task automatic ref_copy();
        for (int w = 0; w < 128; w++) begin
            if (exp_active) ref_mem[w] = ref_mem[128 + w];
            else            ref_mem[128 + w] = ref_mem[w];
        end
    endtask

    // Optional commit, optional control packet, then a video SOP; returns on the swap cycle.
    task automatic sop_seq(input bit do_commit, input bit ctrl_first);
        @(negedge clk);
        if (do_commit) begin
            commit = 1;
            @(negedge clk);
            commit = 0;
            #1 chk("commit_pending_set", commit_pending, 1);
        end
        if (ctrl_first) begin
            drive_vid(10'h00F);
            @(negedge clk);
            vid_off();
            #1;
            chk("ctrl_pkt_no_swap", active_bank, exp_active);
            chk("ctrl_pkt_no_swap_done", swap_done, 0);
        end
        drive_vid(10'h3A0);
        @(negedge clk);
        vid_off();
        exp_active = ~exp_active;
        #1;
        chk("swap_active_bank", active_bank, exp_active);
        chk("swap_done_pulse", swap_done, 1);
        chk("swap_copy_busy", copy_busy, 1);
    endtask

    // Counts copy_busy cycles starting at the swap cycle; injects commit/SOP/reset at given cycles.
    task automatic copy_run(input int commit_at, input int sop_at, input int reset_at,
                            output int busy, output int stalls);
        busy = 0; stalls = 0;
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) @(negedge clk);
            commit = (k == commit_at);
            if (k == sop_at) drive_vid(10'h120); else vid_off();
            if (k == reset_at) rst_n = 0;
            #1;
            if (k == 1) chk("swap_done_one_cycle", swap_done, 0);
            if (!copy_busy) break;
            busy++;
            if (h_waitrequest) stalls++;
        end
        commit = 0;
        vid_off();
    endtask

    typedef struct {
        logic hr, hw, cw;
        logic [6:0] ha, ca;
        logic [3:0] hbe;
        logic [31:0] hwd, cwd;
        logic e_hwait, e_cwait, e_rd, e_wr;
        logic [7:0] e_addr;
        logic [3:0] e_be;
        logic [31:0] e_wd;
        logic e_rdv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy, stalls;
        logic        m_last_host, m_rdv, r_hr, r_hw, r_cw, win_h, win_c;
        logic [31:0] m_rdat;

        for (int a = 0; a < 256; a++) begin mem[a] = '0; ref_mem[a] = '0; end
        ram_readdata = '0;
        idle_inputs();
        rst_n = 0;
        #12;
        chk("rst_active_bank", active_bank, 0);
        chk("rst_commit_pending", commit_pending, 0);
        chk("rst_copy_busy", copy_busy, 0);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_rdv", h_readdatavalid, 0);
        chk("rst_strobes", {ram_read, ram_write}, 0);
        chk("rst_waits", {h_waitrequest, c_waitrequest}, 0);
        @(negedge clk);
        rst_n = 1;

        // Contention from reset alternates H,C,H,C,H,C; then single-requester and read cases.
        vecs[0]  = '{0,1,1,7'd1,7'd2,4'hF,32'h11111111,32'h22222222, 0,1,0,1, 8'h81,4'hF,32'h11111111, 0,32'h0};
        vecs[1]  = '{0,1,1,7'd1,7'd2,4'hF,32'h11111111,32'h22222222, 1,0,0,1, 8'h82,4'hF,32'h22222222, 0,32'h0};
        vecs[2]  = vecs[0];
        vecs[3]  = vecs[1];
        vecs[4]  = vecs[0];
        vecs[5]  = vecs[1];
        vecs[6]  = '{0,1,0,7'd5,7'd0,4'hF,32'h12345678,32'h0, 0,0,0,1, 8'h85,4'hF,32'h12345678, 0,32'h0};
        vecs[7]  = '{1,0,0,7'd5,7'd0,4'hF,32'h0,32'h0, 0,0,1,0, 8'h85,4'hF,32'h0, 0,32'h0};
        vecs[8]  = '{0,0,0,7'd0,7'd0,4'hF,32'h0,32'h0, 0,0,0,0, 8'h00,4'hF,32'h0, 1,32'h12345678};
        vecs[9]  = '{1,1,0,7'd5,7'd0,4'h3,32'hFFFFFFFF,32'h0, 0,0,1,0, 8'h85,4'h3,32'h0, 0,32'h0};
        vecs[10] = '{0,0,0,7'd0,7'd0,4'hF,32'h0,32'h0, 0,0,0,0, 8'h00,4'hF,32'h0, 1,32'h12345678};
        vecs[11] = '{0,1,1,7'd6,7'd7,4'h5,32'hAABBCCDD,32'h55AA55AA, 1,0,0,1, 8'h87,4'hF,32'h55AA55AA, 0,32'h0};
        vecs[12] = '{0,1,0,7'd6,7'd0,4'h5,32'hAABBCCDD,32'h0, 0,0,0,1, 8'h86,4'h5,32'hAABBCCDD, 0,32'h0};
        vecs[13] = '{1,0,0,7'd6,7'd0,4'hF,32'h0,32'h0, 0,0,1,0, 8'h86,4'hF,32'h0, 0,32'h0};
        vecs[14] = '{0,0,0,7'd0,7'd0,4'hF,32'h0,32'h0, 0,0,0,0, 8'h00,4'hF,32'h0, 1,32'h00BB00DD};

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            h_read = vecs[i].hr; h_write = vecs[i].hw; c_write = vecs[i].cw;
            h_address = vecs[i].ha; c_address = vecs[i].ca; h_byteenable = vecs[i].hbe;
            h_writedata = vecs[i].hwd; c_writedata = vecs[i].cwd;
            #1;
            chk($sformatf("v%0d_hwait", i), h_waitrequest, vecs[i].e_hwait);
            chk($sformatf("v%0d_cwait", i), c_waitrequest, vecs[i].e_cwait);
            chk($sformatf("v%0d_rd", i), ram_read, vecs[i].e_rd);
            chk($sformatf("v%0d_wr", i), ram_write, vecs[i].e_wr);
            if (vecs[i].e_rd || vecs[i].e_wr) begin
                chk($sformatf("v%0d_addr", i), ram_address, vecs[i].e_addr);
                chk($sformatf("v%0d_be", i), ram_byteenable, vecs[i].e_be);
            end
            if (vecs[i].e_wr) begin
                chk($sformatf("v%0d_wdata", i), ram_writedata, vecs[i].e_wd);
                ref_mem[vecs[i].e_addr] = merge(ref_mem[vecs[i].e_addr], vecs[i].e_wd, vecs[i].e_be);
            end
            chk($sformatf("v%0d_rdv", i), h_readdatavalid, vecs[i].e_rdv);
            if (vecs[i].e_rdv) chk($sformatf("v%0d_rdata", i), h_readdata, vecs[i].e_rdata);
        end

        // Random traffic into the shadow bank; the last grant above went to the host.
        m_last_host = 1; m_rdv = 0; m_rdat = '0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r_hr = ($urandom_range(0, 3) == 0);
            r_hw = ($urandom_range(0, 2) == 0);
            r_cw = ($urandom_range(0, 1) == 1);
            h_read = r_hr; h_write = r_hw; c_write = r_cw;
            h_address = 7'($urandom_range(0, 127));
            c_address = 7'($urandom_range(0, 127));
            h_byteenable = 4'($urandom_range(0, 15));
            h_writedata = $urandom; c_writedata = $urandom;
            #1;
            chk("rnd_rdv", h_readdatavalid, m_rdv);
            if (m_rdv) chk("rnd_rdata", h_readdata, m_rdat);
            win_h = (r_hr || r_hw) && (!r_cw || !m_last_host);
            win_c = r_cw && !win_h;
            chk("rnd_hwait", h_waitrequest, (r_hr || r_hw) && !win_h);
            chk("rnd_cwait", c_waitrequest, r_cw && !win_c);
            m_rdv = win_h && r_hr;
            if (m_rdv) m_rdat = ref_mem[{~exp_active, h_address}];
            if (win_h && r_hw && !r_hr)
                ref_mem[{~exp_active, h_address}] =
                    merge(ref_mem[{~exp_active, h_address}], h_writedata, h_byteenable);
            if (win_c) ref_mem[{~exp_active, c_address}] = c_writedata;
            if (win_h) m_last_host = 1; else if (win_c) m_last_host = 0;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rnd_last_rdv", h_readdatavalid, m_rdv);
        if (m_rdv) chk("rnd_last_rdata", h_readdata, m_rdat);
        check_banks("rnd_ram_contents");

        // Commit, control packet ignored, video SOP swaps; host write stalls for the whole copy.
        sop_seq(1, 1);
        chk("swap_clears_pending", commit_pending, 0);
        h_write = 1; h_address = 7'd3; h_writedata = 32'hDEADBEEF; h_byteenable = 4'hF;
        copy_run(-1, -1, -1, busy, stalls);
        chk("copy_len", busy, 256);
        chk("copy_host_stalls", stalls, 256);
        chk("post_copy_hwait", h_waitrequest, 0);
        chk("post_copy_hwrite", ram_write, 1);
        chk("post_copy_haddr", ram_address, 8'h03);
        ref_copy();
        ref_mem[3] = 32'hDEADBEEF;
        @(negedge clk);
        h_write = 0;
        #1 check_banks("copy1_banks");

        // Commit mid-copy latches; SOP during copy is ignored; swap at first SOP afterwards.
        sop_seq(1, 0);
        copy_run(10, 100, -1, busy, stalls);
        chk("copy2_len", busy, 256);
        chk("latched_pending", commit_pending, 1);
        chk("no_swap_during_copy", active_bank, exp_active);
        ref_copy();
        sop_seq(0, 0);
        chk("second_swap_pending_clr", commit_pending, 0);
        copy_run(-1, -1, -1, busy, stalls);
        chk("copy3_len", busy, 256);
        ref_copy();
        check_banks("copy3_banks");

        // Reset at copy index 40 (COPY_RD of word 40 is copy cycle 80).
        sop_seq(1, 0);
        copy_run(-1, -1, 80, busy, stalls);
        chk("reset_at_idx40_cycle", busy, 80);
        chk("mid_rst_active_bank", active_bank, 0);
        chk("mid_rst_commit_pending", commit_pending, 0);
        chk("mid_rst_copy_busy", copy_busy, 0);
        chk("mid_rst_swap_done", swap_done, 0);
        chk("mid_rst_rdv", h_readdatavalid, 0);
        chk("mid_rst_strobes", {ram_read, ram_write}, 0);
        chk("mid_rst_waits", {h_waitrequest, c_waitrequest}, 0);
        exp_active = 0;
        @(negedge clk);
        rst_n = 1;
        drive_vid(10'h000);
        @(negedge clk);
        vid_off();
        #1;
        chk("idle_sop_no_swap", active_bank, 0);
        chk("idle_sop_no_busy", copy_busy, 0);
        sop_seq(1, 0);
        copy_run(-1, -1, -1, busy, stalls);
        chk("copy4_len", busy, 256);
        ref_copy();
        check_banks("copy4_banks");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blind_pixel_table_ctrl.md
# blind_pixel_table_ctrl

Double-buffered controller for the blind-pixel correction table RAM. It lets two requesters share the RAM's single maintenance port: the Avalon-MM host and the on-chip calibration writer. Both only ever touch the shadow bank, while the pixel processor reads the active bank. On a host commit, the block swaps banks at the next accepted video start-of-frame, then copies the new active bank into the new shadow bank so incremental edits start from the live table.

## Interface
Parameters:
- ADDR_WIDTH, 7, word address width of one bank; RAM holds 2 banks of 2^ADDR_WIDTH 32-bit words
- DATA_WIDTH, 10, width of snooped video data

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- h_address  in  ADDR_WIDTH  host word address within shadow bank
- h_read / h_write  in  1  host read / write request
- h_writedata  in  32  host write data
- h_byteenable  in  4  host byte enables
- h_waitrequest  out  1  host stall
- h_readdata  out  32  host read data
- h_readdatavalid  out  1  host read data valid
- c_address  in  ADDR_WIDTH  calibration word address within shadow bank
- c_write  in  1  calibration write request; full-word writes only
- c_writedata  in  32  calibration write data
- c_waitrequest  out  1  calibration stall
- commit  in  1  single-cycle request to swap banks
- commit_pending  out  1  swap requested, not yet performed
- copy_busy  out  1  post-swap bank copy in progress
- swap_done  out  1  one-cycle pulse on the swap cycle
- active_bank  out  1  bank read by the pixel processor; drives processor address MSB
- vid_data  in  DATA_WIDTH  snooped Avalon-ST video input data
- vid_valid / vid_ready / vid_sop  in  1  snooped handshake and start-of-packet
- ram_address  out  ADDR_WIDTH+1  {bank, word}
- ram_read / ram_write  out  1  RAM read / write strobe
- ram_writedata  out  32  RAM write data
- ram_byteenable  out  4  RAM byte enables
- ram_readdata  in  32  RAM read data, 1-cycle read latency

## Operation
- Shadow bank is ~active_bank. Host and calibration addresses map to {~active_bank, word}.
- Arbitration is round-robin and resolved combinationally each cycle:
  - With both requesters asserting, the one not granted last wins.
  - The loser's waitrequest is 1. A lone requester is granted immediately.
  - The last-grant pointer resets to "calibration", so the host wins the first contention.
- An idle requester sees waitrequest 0.
- Host read and write asserted together is illegal; the read takes precedence.
- ram_byteenable is h_byteenable for host accesses and 4'hF for calibration and copy accesses.
- Commit FSM states: IDLE, PENDING, COPY_RD, COPY_WR.
  - IDLE: commit -> PENDING.
  - PENDING: a video-frame SOP is `vid_valid & vid_ready & vid_sop & vid_data[3:0]==0`. On one, active_bank toggles, swap_done pulses, the copy index clears, and the FSM goes to COPY_RD. Control packets (type != 0) are ignored.
  - COPY_RD: ram_read of {active_bank, idx} -> COPY_WR.
  - COPY_WR: ram_write of {~active_bank, idx} with ram_readdata. If idx is at its maximum, go to IDLE; otherwise increment idx and go to COPY_RD.
- During COPY_RD and COPY_WR, copy owns the RAM port: both waitrequests are 1 and copy_busy is 1.
- commit arriving in COPY_RD/COPY_WR sets a latched request. The FSM goes to PENDING on leaving COPY_WR instead of IDLE.
- commit in PENDING is absorbed, with no double swap.
- commit_pending is 1 in PENDING and whenever the latched request is set.
- A frame SOP arriving outside PENDING has no effect.

## Timing
- Reset values:
  - active_bank 0, commit_pending 0, copy_busy 0, swap_done 0, h_readdatavalid 0, FSM IDLE.
  - RAM strobes 0, waitrequests 0.
  - Reset mid-copy aborts the copy; the shadow contents are then undefined.
- Host read granted in cycle N: h_readdatavalid = 1 and h_readdata = ram_readdata in cycle N+1. Maximum one outstanding read.
- Writes complete in the grant cycle.
- A swap takes effect in the cycle after the SOP beat: active_bank and swap_done are registered.
- A host access granted in the SOP cycle still targets the old shadow bank.
- A copy occupies exactly 2*2^ADDR_WIDTH cycles (256 at the default).
- Worst-case requester stall under contention is 1 cycle, excluding copy.

## Test plan
- Reset, then a host write of 0x12345678 to word 5 -> RAM write to address 0x85 in the same cycle; read back gives h_readdatavalid 1 cycle later with 0x12345678.
- Host and calibration both requesting continuously for 6 cycles -> grants alternate H,C,H,C,H,C; each waitrequest is high on the alternate cycles.
- Pulse commit, then send a control packet (type 0xF) followed by a video SOP -> no swap on the control packet. active_bank goes 0->1 the cycle after the video SOP, swap_done pulses once, and copy_busy stays high for 256 cycles.
- After the copy, the bank 0 words equal the bank 1 words; a host write to word 3 during the copy stalls until copy_busy falls.
- Commit asserted mid-copy -> commit_pending stays 1, and the second swap occurs at the first video SOP after the copy ends.
- Assert rst_n low at copy index 40 -> all outputs return to reset values, active_bank = 0, FSM IDLE.
